vga_ram_port_sched: RTL

- Sequencer and arbiter for port A of the 2048x32 dual-port VGA text RAM. Port B stays owned by the display scan-out.
- Passes CPU bus accesses straight through to port A.
- Uses free port-A cycles to run hardware screen commands: scroll up one row, fill screen, fill one row. The CPU does not have to loop over 2000 words.
- Sits between the MIPS32SOC memory decoder and the RAM's clka/enablea/wea/addra/wda/rda port.

---
 rtl/vga_ram_port_sched.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/vga_ram_port_sched.sv
// Port-A sequencer for the 2048x32 VGA text RAM.
// CPU accesses pass straight through with absolute priority. Free cycles run
// the screen engine: scroll up one row, fill the whole screen, or fill one row.
module vga_ram_port_sched #(
  parameter int ROW_WORDS = 80,
  parameter int NUM_ROWS  = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic [3:0]  cpu_we,
  input  logic [10:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  output logic [31:0] cpu_rd,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_row,
  input  logic [31:0] cmd_fill,
  output logic        cmd_ready,
  output logic        busy,
  output logic        done,
  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic [10:0] ram_addr,
  output logic [31:0] ram_wd,
  input  logic [31:0] ram_rd
);

  localparam int          COPY_WORDS    = (NUM_ROWS - 1) * ROW_WORDS;
  localparam logic [10:0] ROW_OFS       = 11'(ROW_WORDS);
  localparam logic [10:0] COPY_LAST     = 11'(COPY_WORDS - 1);
  localparam logic [10:0] LAST_ROW_BASE = 11'(COPY_WORDS);
  localparam logic [11:0] SCREEN_CNT    = 12'(ROW_WORDS * NUM_ROWS);
  localparam logic [11:0] ROW_CNT       = 12'(ROW_WORDS);

  typedef enum logic [2:0] {IDLE, COPY_RD, COPY_WR, FILL, DONE} state_t;

  state_t      state;
  logic [10:0] idx;
  logic [10:0] base;
  logic [11:0] cnt;
  logic [31:0] hold;
  logic [31:0] fill;

  logic [10:0] row_base;
  logic        row_ok;
  logic        fill_last;

  // Row base only matters when the row is on screen, so 11 bits never overflow.
  assign row_base  = 11'(cmd_row) * ROW_OFS;
  assign row_ok    = (int'(cmd_row) < NUM_ROWS);
  assign fill_last = ({1'b0, idx} == (cnt - 12'd1));

  // Command engine: advances only on cycles the CPU leaves free; status flags registered with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      base      <= '0;
      cnt       <= '0;
      hold      <= '0;
      fill      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            fill      <= cmd_fill;
            idx       <= '0;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            case (cmd_op)
              2'b00: begin
                state <= COPY_RD;
                base  <= '0;
                cnt   <= ROW_CNT;
              end
              2'b01: begin
                state <= FILL;
                base  <= '0;
                cnt   <= SCREEN_CNT;
              end
              2'b10: begin
                if (row_ok) begin
                  state <= FILL;
                  base  <= row_base;
                  cnt   <= ROW_CNT;
                end else begin
                  state <= DONE;
                  done  <= 1'b1;
                end
              end
              default: begin
                state <= DONE;
                done  <= 1'b1;
              end
            endcase
          end
        end
        COPY_RD: begin
          if (!cpu_en) begin
            hold  <= ram_rd;
            state <= COPY_WR;
          end
        end
        COPY_WR: begin
          if (!cpu_en) begin
            if (idx == COPY_LAST) begin
              // Copy finished: blank the freed bottom row with the fill word.
              state <= FILL;
              base  <= LAST_ROW_BASE;
              idx   <= '0;
              cnt   <= ROW_CNT;
            end else begin
              idx   <= idx + 11'd1;
              state <= COPY_RD;
            end
          end
        end
        FILL: begin
          if (!cpu_en) begin
            idx <= idx + 11'd1;
            if (fill_last) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  // Port-A mux: CPU overrides whatever step the engine would take this cycle.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 4'h0;
    ram_addr = '0;
    ram_wd   = '0;
    case (state)
      COPY_RD: begin
        ram_en   = 1'b1;
        ram_addr = idx + ROW_OFS;
      end
      COPY_WR: begin
        ram_en   = 1'b1;
        ram_we   = 4'hF;
        ram_addr = idx;
        ram_wd   = hold;
      end
      FILL: begin
        ram_en   = 1'b1;
        ram_we   = 4'hF;
        ram_addr = base + idx;
        ram_wd   = fill;
      end
      default: ;
    endcase
    if (cpu_en) begin
      ram_en   = 1'b1;
      ram_we   = cpu_we;
      ram_addr = cpu_addr;
      ram_wd   = cpu_wd;
    end
  end

  assign cpu_rd = cpu_en ? ram_rd : 32'h0;

endmodule
